// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the sequential partial-product multiplier.
//
// Contents:
//   - State encodings for the controller FSM (IDLE, RUN, FINISH, ERROR).
//     The encoding is fixed so the datapath and bench can decode it directly.
//   - clog2_min1(): $clog2 that never returns less than 1. Widths derived
//     from it are always legal, even when PARTS is 1.
package mult_ctrl_pkg;

  localparam logic [2:0] IDLE   = 3'b000;
  localparam logic [2:0] RUN    = 3'b001;
  localparam logic [2:0] FINISH = 3'b101;
  localparam logic [2:0] ERROR  = 3'b111;

  function automatic int clog2_min1(input int value);
    int r;
    r = $clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/step_counter.sv
// Step counter for the multiplier controller.
//
// Ports:
//   clk_i   - rising-edge clock
//   rst_ni  - asynchronous active-low reset (count -> 0)
//   clr_i   - synchronous clear to 0; has priority over en_i
//   en_i    - increment by one
//   cnt_o   - current count
//   last_o  - count equals N-1 (final slice pair)
module step_counter #(
  parameter int N      = 4,
  parameter int STEP_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [STEP_W-1:0] cnt_o,
  output logic              last_o
);

  logic [STEP_W-1:0] cnt_q;
  logic [STEP_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == STEP_W'(N - 1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// Control FSM for the sequential partial-product multiplier.
//
// Each operand is split into PARTS slices; the controller walks all
// PARTS*PARTS slice pairs, one per cycle, most-significant pair first, and
// drives the slice selects, the shift amount, the accumulator load/add
// select and the datapath register enable.
//
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-low reset
//   start        - begin a multiply (honoured in IDLE, ERROR, FINISH)
//   changed      - operand modified during RUN -> ERROR
//   abort        - cancel the operation -> IDLE
//   ack          - consumer accepted the result, releases FINISH
//   state        - current FSM state encoding
//   step         - current step index k
//   sela / selb  - A / B slice index for step k
//   sel_shifter  - partial-product shift in slice units (sela + selb)
//   data_sel     - 1 = accumulator loads, 0 = accumulator adds
//   clk_en       - datapath register enable
//   done_flag    - result valid (FINISH)
//   err_flag     - operation corrupted by changed (ERROR)
//   locked       - controller busy (state != IDLE)
//
// Result handshake: done_flag rises on entry to FINISH and stays high until
// a cycle in which ack is sampled high; the controller is in IDLE on the
// following cycle. A start sampled in FINISH wins over ack and restarts RUN
// at step 0 directly, so back-to-back multiplies lose no cycles.
module mult_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int PARTS  = 2,
  parameter int IDX_W  = clog2_min1(PARTS),
  parameter int SH_W   = clog2_min1(2 * PARTS - 1),
  parameter int STEP_W = clog2_min1(PARTS * PARTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              changed,
  input  logic              abort,
  input  logic              ack,
  output logic [2:0]        state,
  output logic [STEP_W-1:0] step,
  output logic [IDX_W-1:0]  sela,
  output logic [IDX_W-1:0]  selb,
  output logic [SH_W-1:0]   sel_shifter,
  output logic              data_sel,
  output logic              clk_en,
  output logic              done_flag,
  output logic              err_flag,
  output logic              locked
);

  localparam int N = PARTS * PARTS;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_last;
  logic [STEP_W-1:0] step_cnt;

  // ---------------------------------------------------------------------
  // Step counter: cleared on every entry to RUN, advanced only while RUN
  // continues, otherwise it holds its last value.
  // ---------------------------------------------------------------------
  step_counter #(
    .N      (N),
    .STEP_W (STEP_W)
  ) u_step_counter (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (step_cnt),
    .last_o (cnt_last)
  );

  // ---------------------------------------------------------------------
  // Next-state logic. Priority inside RUN is abort > changed > last step.
  // In ERROR abort also beats start.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (changed) begin
          state_d = ERROR;
        end else if (cnt_last) begin
          state_d = FINISH;
        end else begin
          cnt_en = 1'b1;
        end
      end
      FINISH: begin
        if (start) begin
          state_d = RUN;
          cnt_clr = 1'b1;
        end else if (ack) begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output decode from state and step.
  // In RUN, step k maps to row k/PARTS and column k%PARTS, counted from the
  // most-significant slice downwards, so the first step (k=0) pairs the two
  // top slices and loads the accumulator; later steps add.
  // IDLE/ERROR park on the first step's selects so the datapath is already
  // lined up when RUN begins; FINISH parks on zero and freezes the registers.
  // ---------------------------------------------------------------------
  always_comb begin
    int k_i;
    int row_i;
    int col_i;
    int sa_i;
    int sb_i;
    k_i         = int'(step_cnt);
    row_i       = k_i / PARTS;
    col_i       = k_i % PARTS;
    sa_i        = PARTS - 1;
    sb_i        = PARTS - 1;
    data_sel    = 1'b1;
    clk_en      = 1'b1;
    done_flag   = 1'b0;
    err_flag    = 1'b0;
    case (state_q)
      RUN: begin
        sa_i     = PARTS - 1 - row_i;
        sb_i     = PARTS - 1 - col_i;
        data_sel = (k_i == 0);
      end
      FINISH: begin
        sa_i      = 0;
        sb_i      = 0;
        clk_en    = 1'b0;
        done_flag = 1'b1;
      end
      ERROR: begin
        err_flag = 1'b1;
      end
      default: begin
        // IDLE and unused encodings keep the parked defaults.
      end
    endcase
    sela        = IDX_W'(sa_i);
    selb        = IDX_W'(sb_i);
    sel_shifter = SH_W'(sa_i + sb_i);
  end

  assign state  = state_q;
  assign step   = step_cnt;
  assign locked = (state_q != IDLE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: one instance with PARTS=2 and one with
// PARTS=3, both driven by the same inputs.
module tb_mult_seq_ctrl;
  import mult_ctrl_pkg::*;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic clk;
  logic rst;
  logic start;
  logic changed;
  logic abort;
  logic ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PARTS=2 instance
  logic [2:0] state2;
  logic [1:0] step2;
  logic [0:0] sela2;
  logic [0:0] selb2;
  logic [1:0] sh2;
  logic       ds2, ce2, done2, err2, lk2;

  // PARTS=3 instance
  logic [2:0] state3;
  logic [3:0] step3;
  logic [1:0] sela3;
  logic [1:0] selb3;
  logic [2:0] sh3;
  logic       ds3, ce3, done3, err3, lk3;

  mult_seq_ctrl #(.PARTS(2)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .changed     (changed),
    .abort       (abort),
    .ack         (ack),
    .state       (state2),
    .step        (step2),
    .sela        (sela2),
    .selb        (selb2),
    .sel_shifter (sh2),
    .data_sel    (ds2),
    .clk_en      (ce2),
    .done_flag   (done2),
    .err_flag    (err2),
    .locked      (lk2)
  );

  mult_seq_ctrl #(.PARTS(3)) dut3 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .changed     (changed),
    .abort       (abort),
    .ack         (ack),
    .state       (state3),
    .step        (step3),
    .sela        (sela3),
    .selb        (selb3),
    .sel_shifter (sh3),
    .data_sel    (ds3),
    .clk_en      (ce3),
    .done_flag   (done3),
    .err_flag    (err3),
    .locked      (lk3)
  );

  // -------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------
  int n_total;
  int n_bad;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packs one observation: state, step, sela, selb, shift, data_sel,
  // clk_en, done_flag, err_flag, locked.
  function automatic logic [31:0] pk(int st, int stp, int a, int b, int sh,
                                     int ds, int ce, int df, int ef, int lk);
    return {13'd0, st[2:0], stp[3:0], a[1:0], b[1:0], sh[2:0],
            ds[0], ce[0], df[0], ef[0], lk[0]};
  endfunction

  function automatic logic [31:0] obs2();
    return pk(int'(state2), int'(step2), int'(sela2), int'(selb2), int'(sh2),
              int'(ds2), int'(ce2), int'(done2), int'(err2), int'(lk2));
  endfunction

  // -------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // -------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------
  initial begin
    int hold;
    logic [31:0] rst_obs;
    n_total = 0;
    n_bad   = 0;
    rst_obs = pk(int'(IDLE), 0, 1, 1, 2, 1, 1, 0, 0, 0);

    rst = 1'b0; start = 1'b0; changed = 1'b0; abort = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_p2", obs2(), rst_obs);
    check("reset_p3_sel", {state3, step3, sela3, selb3, sh3}, {3'd0, 4'd0, 2'd2, 2'd2, 3'd4});
    rst = 1'b1;
    tick();

    // --- Basic multiply: slice sequence, done, held until ack ---------
    exp_q.push_back(pk(int'(RUN), 0, 1, 1, 2, 1, 1, 0, 0, 1));
    exp_q.push_back(pk(int'(RUN), 1, 1, 0, 1, 0, 1, 0, 0, 1));
    exp_q.push_back(pk(int'(RUN), 2, 0, 1, 1, 0, 1, 0, 0, 1));
    exp_q.push_back(pk(int'(RUN), 3, 0, 0, 0, 0, 1, 0, 0, 1));
    exp_q.push_back(pk(int'(FINISH), 3, 0, 0, 0, 1, 0, 1, 0, 1));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check("run_seq", obs2(), exp_q.pop_front());
    end
    hold = $urandom_range(1, 4);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("finish_hold", obs2(), pk(int'(FINISH), 3, 0, 0, 0, 1, 0, 1, 0, 1));
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_idle", obs2(), pk(int'(IDLE), 3, 1, 1, 2, 1, 1, 0, 0, 0));

    // --- changed at step 2 -> ERROR, then restart ---------------------
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(2);
    check("chg_step2", int'(step2), 2);
    changed = 1'b1;
    tick();
    changed = 1'b0;
    check("err_enter", obs2(), pk(int'(ERROR), 2, 1, 1, 2, 1, 1, 0, 1, 1));
    tick();
    check("err_hold", obs2(), pk(int'(ERROR), 2, 1, 1, 2, 1, 1, 0, 1, 1));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_restart", obs2(), pk(int'(RUN), 0, 1, 1, 2, 1, 1, 0, 0, 1));

    // --- abort at step 1 ----------------------------------------------
    tick();
    check("abort_step1", int'(step2), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", obs2(), pk(int'(IDLE), 1, 1, 1, 2, 1, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", {31'd0, done2 | lk2}, 32'd0);
    end

    // --- abort and changed together -> IDLE ---------------------------
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    changed = 1'b1;
    tick();
    abort = 1'b0;
    changed = 1'b0;
    check("abort_chg", obs2(), pk(int'(IDLE), 0, 1, 1, 2, 1, 1, 0, 0, 0));

    // --- back-to-back: start with ack in FINISH -----------------------
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(4);
    check("b2b_fin1", obs2(), pk(int'(FINISH), 3, 0, 0, 0, 1, 0, 1, 0, 1));
    start = 1'b1;
    ack = 1'b1;
    tick();
    start = 1'b0;
    ack = 1'b0;
    check("b2b_restart", obs2(), pk(int'(RUN), 0, 1, 1, 2, 1, 1, 0, 0, 1));
    ticks(3);
    check("b2b_step3", obs2(), pk(int'(RUN), 3, 0, 0, 0, 0, 1, 0, 0, 1));
    tick();
    check("b2b_fin2", obs2(), pk(int'(FINISH), 3, 0, 0, 0, 1, 0, 1, 0, 1));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("b2b_idle", int'(state2), int'(IDLE));

    // --- asynchronous reset mid-RUN at step 3 -------------------------
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(3);
    check("rst_pre_step3", int'(step2), 3);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_p2", obs2(), rst_obs);
    check("rst_async_p3", {state3, step3}, {3'd0, 4'd0});
    tick();
    rst = 1'b1;
    tick();
    check("rst_release", obs2(), rst_obs);

    // --- PARTS=3: nine steps ------------------------------------------
    start = 1'b1;
    tick();
    start = 1'b0;
    check("p3_step0", {state3, step3, sela3, selb3, sh3, ds3}, {3'd1, 4'd0, 2'd2, 2'd2, 3'd4, 1'b1});
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 4) begin
        check("p3_step4", {state3, step3, sela3, selb3, sh3, ds3, ce3},
              {3'd1, 4'd4, 2'd1, 2'd1, 3'd2, 1'b0, 1'b1});
      end
      if (k == 8) begin
        check("p3_step8", {state3, step3, sela3, selb3, sh3, done3},
              {3'd1, 4'd8, 2'd0, 2'd0, 3'd0, 1'b0});
      end
    end
    tick();
    check("p3_done", {state3, done3, ce3, err3}, {3'd5, 1'b1, 1'b0, 1'b0});
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("p3_idle", {state3, lk3, done3}, {3'd0, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
